// File: rtl/display_pkg.sv
// Shared types and constants for the display window pipeline.
// Holds the fade FSM states and the per-channel dimming helper.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    SHOW,
    FADE_OUT
  } fade_state_t;

  localparam logic [7:0]  SHOW_STATE = 8'h03;
  localparam logic [11:0] RGB_BLACK  = 12'h000;

  // level 16 multiplies by 16, so >>4 returns the channel unchanged
  function automatic logic [11:0] dim(
    input logic [11:0] c,
    input logic [4:0]  lvl
  );
    logic [7:0] r, g, b;
    r = 8'(c[11:8]) * 8'(lvl);
    g = 8'(c[7:4])  * 8'(lvl);
    b = 8'(c[3:0])  * 8'(lvl);
    return {r[7:4], g[7:4], b[7:4]};
  endfunction

endpackage

// File: rtl/display_fade_ctrl.sv
// Frame-tick driven fade FSM: steps brightness level 0..16
// once every FADE_FRAMES ticks while fading in or out.
module display_fade_ctrl
  import display_pkg::*;
#(
  parameter int FADE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       show,
  output logic [4:0] level,
  output logic       busy
);

  localparam int DW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [DW-1:0] LAST = DW'(FADE_FRAMES - 1);

  fade_state_t   fsm;
  logic [DW-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      level <= 5'd0;
      div   <= '0;
      busy  <= 1'b0;
    end else if (tick) begin
      unique case (fsm)
        IDLE: begin
          if (show) begin
            fsm  <= FADE_IN;
            div  <= '0;
            busy <= 1'b1;
          end
        end
        FADE_IN: begin
          if (!show) begin
            fsm <= FADE_OUT;
            div <= '0;
          end else if (div == LAST) begin
            div   <= '0;
            level <= level + 5'd1;
            if (level == 5'd15) begin
              fsm  <= SHOW;
              busy <= 1'b0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        SHOW: begin
          if (!show) begin
            fsm  <= FADE_OUT;
            div  <= '0;
            busy <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (show) begin
            fsm <= FADE_IN;
            div <= '0;
          end else if (level == 5'd0) begin
            // aborted before the first step up; nothing to fade
            fsm  <= IDLE;
            div  <= '0;
            busy <= 1'b0;
          end else if (div == LAST) begin
            div   <= '0;
            level <= level - 5'd1;
            if (level == 5'd1) begin
              fsm  <= IDLE;
              busy <= 1'b0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/display_window.sv
// Scaled image window with border, RAM address generation and
// latency-matched region pipeline feeding a fading RGB444 output.
module display_window
  import display_pkg::*;
#(
  parameter int          W            = 200,
  parameter int          H            = 150,
  parameter int          STARTROW     = 0,
  parameter int          STARTCOL     = 0,
  parameter int          SCALE_LOG2   = 0,
  parameter int          RAM_LAT      = 1,
  parameter int          BORDER_W     = 4,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter int          FADE_FRAMES  = 2,
  parameter int          ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [7:0]        state,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [11:0]       pixel_data,
  output logic [11:0]       VGA_RGB,
  output logic              fade_busy
);

  localparam int WS = W << SCALE_LOG2;
  localparam int HS = H << SCALE_LOG2;

  localparam logic signed [13:0] X0  = 14'(STARTCOL);
  localparam logic signed [13:0] X1  = 14'(STARTCOL + WS);
  localparam logic signed [13:0] BX0 = 14'(STARTCOL - BORDER_W);
  localparam logic signed [13:0] BX1 = 14'(STARTCOL + WS + BORDER_W);
  localparam logic signed [13:0] Y0  = 14'(STARTROW);
  localparam logic signed [13:0] Y1  = 14'(STARTROW + HS);
  localparam logic signed [13:0] BY0 = 14'(STARTROW - BORDER_W);
  localparam logic signed [13:0] BY1 = 14'(STARTROW + HS + BORDER_W);

  logic signed [13:0] xs, ys;
  logic [13:0]        dx, dy;
  logic [11:0]        col, row;
  logic [ADDR_W-1:0]  addr_next;
  logic               in_win, in_bord;
  logic               origin, prev_origin, tick, show;
  logic [RAM_LAT:0]   win_d, bord_d;
  logic [11:0]        src;
  logic [4:0]         level;

  assign xs = $signed({2'b00, xpos});
  assign ys = $signed({2'b00, ypos});
  assign dx = xs - X0;
  assign dy = ys - Y0;
  assign col = 12'(dx >> SCALE_LOG2);
  assign row = 12'(dy >> SCALE_LOG2);
  assign addr_next = ADDR_W'(32'(row) * 32'(W) + 32'(col));

  assign in_win = (xs >= X0) && (xs < X1) &&
                  (ys >= Y0) && (ys < Y1);
  assign in_bord = !in_win &&
                   (xs >= BX0) && (xs < BX1) &&
                   (ys >= BY0) && (ys < BY1);

  // prev_origin resets low so a reset released at (0,0) still ticks
  assign origin = (xpos == 12'd0) && (ypos == 12'd0);
  assign tick   = origin && !prev_origin;
  assign show   = (state == SHOW_STATE);

  display_fade_ctrl #(
    .FADE_FRAMES(FADE_FRAMES)
  ) u_fade (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .show (show),
    .level(level),
    .busy (fade_busy)
  );

  always_comb begin
    src = RGB_BLACK;
    unique case (1'b1)
      win_d[RAM_LAT]:  src = pixel_data;
      bord_d[RAM_LAT]: src = BORDER_COLOR;
      default:         src = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_origin <= 1'b0;
      ram_addr    <= '0;
      win_d       <= '0;
      bord_d      <= '0;
      VGA_RGB     <= RGB_BLACK;
    end else begin
      prev_origin <= origin;
      if (in_win) ram_addr <= addr_next;
      win_d   <= {win_d[RAM_LAT-1:0], in_win};
      bord_d  <= {bord_d[RAM_LAT-1:0], in_bord};
      VGA_RGB <= dim(src, level);
    end
  end

endmodule

// File: tb/tb_display_window.sv
// Directed bench for display_window: defaults, 2x scaling and
// 3-cycle RAM latency instances driven by one shared scan.
module tb_display_window;

  localparam int PARK = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos, ypos;
  logic [7:0]  state;

  logic [14:0] addr_def, addr_scl, addr_lat;
  logic [11:0] pix_def, pix_scl, pix_lat;
  logic [11:0] vga_def, vga_scl, vga_lat;
  logic        busy_def, busy_scl, busy_lat;
  logic [11:0] lat_pipe [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_window u_def (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
    .state(state), .ram_addr(addr_def), .pixel_data(pix_def),
    .VGA_RGB(vga_def), .fade_busy(busy_def)
  );

  display_window #(.SCALE_LOG2(1)) u_scl (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
    .state(state), .ram_addr(addr_scl), .pixel_data(pix_scl),
    .VGA_RGB(vga_scl), .fade_busy(busy_scl)
  );

  display_window #(.STARTROW(4), .STARTCOL(4), .RAM_LAT(3)) u_lat (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
    .state(state), .ram_addr(addr_lat), .pixel_data(pix_lat),
    .VGA_RGB(vga_lat), .fade_busy(busy_lat)
  );

  // pixel RAM models return the low 12 address bits
  always @(posedge clk) begin
    pix_def <= addr_def[11:0];
    pix_scl <= addr_scl[11:0];
    lat_pipe[0] <= addr_lat[11:0];
    lat_pipe[1] <= lat_pipe[0];
    lat_pipe[2] <= lat_pipe[1];
  end
  assign pix_lat = lat_pipe[2];

  task automatic step(input int x, input int y);
    @(negedge clk);
    xpos = 12'(x);
    ypos = 12'(y);
  endtask

  task automatic frame();
    step(0, 0);
    step(PARK, PARK);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    state = 8'h00;
    xpos  = 12'd0;
    ypos  = 12'd0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_vga: got %h want 000", vga_def);
    end
    n_checks++;
    if (addr_def !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d want 0", addr_def);
    end
    n_checks++;
    if (busy_def !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy_def);
    end
    state = 8'h03;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_def !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick_busy: got %b want 1", busy_def);
    end
    step(PARK, PARK);
  endtask

  task automatic test_fade_in();
    frames(16);
    step(183, 19);
    @(negedge clk);
    n_checks++;
    if (addr_def !== 15'd3983) begin
      n_fail++;
      $display("FAIL lvl8_addr: got %0d want 3983", addr_def);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h747) begin
      n_fail++;
      $display("FAIL lvl8_vga: got %h want 747", vga_def);
    end
    step(PARK, PARK);
    frames(15);
    n_checks++;
    if (busy_def !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_lvl15: got %b want 1", busy_def);
    end
    frame();
    n_checks++;
    if (busy_def !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_show: got %b want 0", busy_def);
    end
  endtask

  task automatic test_window();
    step(5, 2);
    @(negedge clk);
    n_checks++;
    if (addr_def !== 15'd405) begin
      n_fail++;
      $display("FAIL win_addr: got %0d want 405", addr_def);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h195) begin
      n_fail++;
      $display("FAIL win_vga: got %h want 195", vga_def);
    end
    step(PARK, PARK);
    @(negedge clk);
    n_checks++;
    if (addr_def !== 15'd405) begin
      n_fail++;
      $display("FAIL addr_hold: got %0d want 405", addr_def);
    end
  endtask

  task automatic test_scale();
    int          xs [6] = '{399, 400, 403, 404, 10, 10};
    int          ys [6] = '{0, 0, 0, 0, 300, 304};
    logic [11:0] ex [6] = '{12'h0C7, 12'hFFF, 12'hFFF,
                            12'h000, 12'hFFF, 12'h000};
    for (int i = 0; i < 6; i++) begin
      step(xs[i], ys[i]);
      repeat (3) @(negedge clk);
      n_checks++;
      if (vga_scl !== ex[i]) begin
        n_fail++;
        $display("FAIL scale_x%0d_y%0d: got %h want %h",
                 xs[i], ys[i], vga_scl, ex[i]);
      end
    end
    step(PARK, PARK);
  endtask

  task automatic test_latency();
    step(3, 5);
    repeat (6) @(negedge clk);
    step(4, 5);
    repeat (4) @(negedge clk);
    n_checks++;
    if (vga_lat !== 12'hFFF) begin
      n_fail++;
      $display("FAIL lat3_edge3: got %h want FFF", vga_lat);
    end
    @(negedge clk);
    n_checks++;
    if (vga_lat !== 12'h0C8) begin
      n_fail++;
      $display("FAIL lat3_edge4: got %h want 0C8", vga_lat);
    end
    step(PARK, PARK);
  endtask

  task automatic test_reset_mid();
    step(50, 10);
    repeat (3) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h802) begin
      n_fail++;
      $display("FAIL show_pre_rst: got %h want 802", vga_def);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vga_def !== 12'h000 || addr_def !== 15'd0) begin
      n_fail++;
      $display("FAIL async_rst: got vga %h addr %0d want 000 0",
               vga_def, addr_def);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_def !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_rst: got %b want 0", busy_def);
    end
    step(PARK, PARK);
    frame();
    step(95, 20);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_def !== 1'b1 || vga_def !== 12'h000) begin
      n_fail++;
      $display("FAIL restart_lvl0: got busy %b vga %h want 1 000",
               busy_def, vga_def);
    end
    step(PARK, PARK);
    frames(4);
    step(95, 20);
    repeat (3) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h111) begin
      n_fail++;
      $display("FAIL restart_lvl2: got %h want 111", vga_def);
    end
    step(PARK, PARK);
  endtask

  task automatic test_fade_out();
    frames(16);
    step(95, 20);
    repeat (3) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h999) begin
      n_fail++;
      $display("FAIL lvl10_vga: got %h want 999", vga_def);
    end
    step(PARK, PARK);
    state = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_def !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: got %b want 1", busy_def);
    end
    frame();
    step(95, 20);
    repeat (3) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h999) begin
      n_fail++;
      $display("FAIL fadeout_keep: got %h want 999", vga_def);
    end
    step(PARK, PARK);
    frames(19);
    n_checks++;
    if (busy_def !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_lvl1: got %b want 1", busy_def);
    end
    frame();
    n_checks++;
    if (busy_def !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle: got %b want 0", busy_def);
    end
    step(95, 20);
    repeat (3) @(negedge clk);
    n_checks++;
    if (vga_def !== 12'h000) begin
      n_fail++;
      $display("FAIL idle_vga: got %h want 000", vga_def);
    end
    step(PARK, PARK);
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_window();
    test_scale();
    test_latency();
    test_reset_mid();
    test_fade_out();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_window.md
DISPLAY_WINDOW -- requirements
Module: display_window

Interface
REQ-001 Parameter W, default 200: source image width in pixels.
REQ-002 Parameter H, default 150: source image height in pixels.
REQ-003 Parameter STARTROW, default 0: screen row of the window's top edge.
REQ-004 Parameter STARTCOL, default 0: screen column of the window's left edge.
REQ-005 Parameter SCALE_LOG2, default 0, legal 0..2: the window is upscaled by 2^SCALE_LOG2 in each axis.
REQ-006 Parameter RAM_LAT, default 1, legal 1..3: read latency of the external pixel RAM in clk cycles.
REQ-007 Parameter BORDER_W, default 4: frame border thickness in screen pixels; 0 disables the border.
REQ-008 Parameter BORDER_COLOR, default 12'hFFF: border RGB444 colour.
REQ-009 Parameter FADE_FRAMES, default 2: frames per brightness step (minimum 1).
REQ-010 Parameter ADDR_W, default 15: RAM address width, at least clog2(W*H).
REQ-011 clk  in  1  pixel clock; one clock; all state on its rising edge.
REQ-012 rst_n  in  1  reset, asynchronous, active-low.
REQ-013 xpos  in  12  current scan column.
REQ-014 ypos  in  12  current scan row.
REQ-015 state  in  8  system state; 8'h03 means show.
REQ-016 ram_addr  out  ADDR_W  registered pixel RAM read address.
REQ-017 pixel_data  in  12  RAM read data, valid RAM_LAT cycles after ram_addr.
REQ-018 VGA_RGB  out  12  registered RGB444 output.
REQ-019 fade_busy  out  1  high while the fade FSM is in FADE_IN or FADE_OUT.

Function
REQ-020 The image window SHALL be half-open: STARTCOL <= xpos < STARTCOL+(W<<SCALE_LOG2), with the same rule in y using STARTROW and H.
REQ-021 The border region SHALL be the pixels outside the window but within BORDER_W of it in x and y; all other pixels are background 12'h000.
REQ-022 Inside the window, ram_addr SHALL be ((ypos-STARTROW)>>SCALE_LOG2)*W + ((xpos-STARTCOL)>>SCALE_LOG2); elsewhere ram_addr holds its previous value.
REQ-023 For xpos/ypos sampled at edge k, ram_addr SHALL update at edge k, and VGA_RGB SHALL update at edge k+RAM_LAT+1. Region flags SHALL be delayed to match.
REQ-024 The pixel source SHALL be pixel_data in the window, BORDER_COLOR in the border, and 12'h000 elsewhere.
REQ-025 Each 4-bit channel SHALL be output as (c*level)>>4 with level 0..16, using an 8-bit intermediate product; level 16 is an exact passthrough.
REQ-026 A frame tick SHALL be a one-cycle pulse on the first cycle where xpos==0 and ypos==0, detected by comparison with the previous cycle.
REQ-027 The FSM states SHALL be IDLE (level 0), FADE_IN, SHOW (level 16) and FADE_OUT; level and state change only on a frame tick.
REQ-028 IDLE SHALL go to FADE_IN on a tick when state==8'h03.
REQ-029 In FADE_IN, level SHALL increment by 1 every FADE_FRAMES ticks; on reaching 16 the FSM goes to SHOW.
REQ-030 From SHOW or FADE_IN, a tick with state!=8'h03 SHALL go to FADE_OUT and keep the current level.
REQ-031 In FADE_OUT, level SHALL decrement every FADE_FRAMES ticks; on reaching 0 the FSM goes to IDLE.
REQ-032 FADE_OUT SHALL go back to FADE_IN on a tick with state==8'h03, keeping the current level.
REQ-033 The frame-divider counter SHALL clear on every FSM state change.
REQ-034 A state change that happens mid-frame SHALL have no effect until the next tick.

Reset
REQ-035 While rst_n is low, the block SHALL hold FSM=IDLE, level=0, divider=0, ram_addr=0, VGA_RGB=12'h000, fade_busy=0, pipeline flags cleared.
REQ-036 After rst_n deasserts, the first tick SHALL be detected correctly even if the coordinate is already (0,0).

Structure
REQ-037 Package display_pkg SHALL hold the FSM state enum, SHOW_STATE=8'h03, and RGB_BLACK=12'h000.
REQ-038 The FSM, divider and level logic SHALL be sub-module display_fade_ctrl (inputs clk, rst_n, tick, show; outputs level[4:0] and busy).
REQ-039 display_window SHALL instantiate display_fade_ctrl and keep the address and region pipeline.

Verification
REQ-040 Defaults, state=03 held, pixel RAM model returning addr[11:0] → level reaches 16 after 32 ticks; then (xpos 5, ypos 2) gives ram_addr 405 and VGA_RGB 12'h195 two cycles later.
REQ-041 SCALE_LOG2=1 → xpos 399 (col 199) is in the window; xpos 400 shows BORDER_COLOR; xpos 404 shows 000; ypos 300 at xpos 10 shows the border.
REQ-042 Level 8 with pixel 12'hF8F → VGA_RGB 12'h747.
REQ-043 state 03→00 at level 10 in FADE_IN → at the next tick FADE_OUT; level 0 after 20 ticks; fade_busy falls with IDLE.
REQ-044 rst_n pulsed low mid-line in SHOW → VGA_RGB 000 immediately, ram_addr 0; FADE_IN restarts from 0 at the first tick after release.
REQ-045 RAM_LAT=3 → border-to-image transition at xpos 4 appears at VGA_RGB exactly 4 edges later, with no stale border pixel.
